// File: rtl/dcd_rr_arbiter_if.sv
// Request/grant bundle between the eight requesters and the decoder arbiter.
interface dcd_rr_arbiter_if;

  logic [7:0] req;         // level request per requester
  logic [2:0] gnt_idx;     // decoder select, index of current owner
  logic       gnt_en;      // decoder enable
  logic [7:0] gnt_onehot;  // decoded grant, (1 << gnt_idx) when enabled
  logic       preempt;     // one-cycle pulse on hold-limit rotation

  // Arbiter side: consumes requests, produces the grant.
  modport master (
    input  req,
    output gnt_idx,
    output gnt_en,
    output gnt_onehot,
    output preempt
  );

  // Requester/decoder side: produces requests, observes the grant.
  modport slave (
    output req,
    input  gnt_idx,
    input  gnt_en,
    input  gnt_onehot,
    input  preempt
  );

endinterface

// File: rtl/dcd_rr_arbiter.sv
// Round-robin arbiter sharing one 3-to-8 decoder among eight requesters.
// The owner keeps the grant while it requests; a hold-limit counter forces
// rotation when others are waiting, so nobody starves. All outputs registered.
module dcd_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned HOLD_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  dcd_rr_arbiter_if.master bus
);

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               en_q, en_d;
  logic [N_REQ-1:0]   onehot_q, onehot_d;
  logic               pre_q, pre_d;

  logic [N_REQ-1:0]   owner_mask_c;
  logic [N_REQ-1:0]   others_c;
  logic [IDX_W:0]     pick_all_c;
  logic [IDX_W:0]     pick_others_c;

  // Round-robin pick: first set bit scanning base+1 .. base+8 (mod 8).
  // Returns {found, index}.
  function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] vec,
                                             input logic [IDX_W-1:0] base);
    logic             found;
    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] cand;
    found = 1'b0;
    win   = '0;
    for (int k = 1; k <= int'(N_REQ); k++) begin
      cand = base + IDX_W'(k);
      if (!found && vec[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    return {found, win};
  endfunction

  // Search candidates for the current cycle: full request set and the
  // request set with the current owner removed.
  always_comb begin
    owner_mask_c  = N_REQ'(1) << idx_q;
    others_c      = bus.req & ~owner_mask_c;
    pick_all_c    = rr_pick(bus.req, ptr_q);
    pick_others_c = rr_pick(others_c, ptr_q);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    idx_d   = idx_q;
    en_d    = en_q;
    pre_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_all_c[IDX_W]) begin
          state_d = ST_GRANT;
          idx_d   = pick_all_c[IDX_W-1:0];
          ptr_d   = pick_all_c[IDX_W-1:0];
          en_d    = 1'b1;
          hold_d  = '0;
        end
      end

      ST_GRANT: begin
        if (!bus.req[idx_q]) begin
          // Owner released: hand over in the same edge, or go idle.
          if (pick_all_c[IDX_W]) begin
            idx_d  = pick_all_c[IDX_W-1:0];
            ptr_d  = pick_all_c[IDX_W-1:0];
            hold_d = '0;
          end else begin
            state_d = ST_IDLE;
            en_d    = 1'b0;
            hold_d  = '0;
          end
        end else if ((hold_q == HOLD_LAST) && (|others_c)) begin
          // Hold limit reached with others waiting: force rotation.
          idx_d  = pick_others_c[IDX_W-1:0];
          ptr_d  = pick_others_c[IDX_W-1:0];
          hold_d = '0;
          pre_d  = 1'b1;
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        en_d    = 1'b0;
      end
    endcase

    onehot_d = en_d ? (N_REQ'(1) << idx_d) : '0;
  end

  // State and output registers; reset clears the grant immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ptr_q    <= IDX_W'(N_REQ - 1);
      hold_q   <= '0;
      idx_q    <= '0;
      en_q     <= 1'b0;
      onehot_q <= '0;
      pre_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      hold_q   <= hold_d;
      idx_q    <= idx_d;
      en_q     <= en_d;
      onehot_q <= onehot_d;
      pre_q    <= pre_d;
    end
  end

  assign bus.gnt_idx    = idx_q;
  assign bus.gnt_en     = en_q;
  assign bus.gnt_onehot = onehot_q;
  assign bus.preempt    = pre_q;

endmodule

// File: doc/dcd_rr_arbiter.md
# dcd_rr_arbiter

Round-robin arbiter that shares the 3-to-8 decoder among eight requesters. Each cycle it picks at most one owner and drives the decoder's 3-bit select and enable directly, plus a registered one-hot copy of the decoded grant. A hold-limit counter forces rotation when the owner keeps its request while others wait, so no requester is starved.

## Interface
- MAX_HOLD, 8: maximum consecutive cycles one owner keeps the grant while another requester is pending; legal range 1..15.
- HOLD_W, 4: width of the hold counter; must satisfy 2^HOLD_W >= MAX_HOLD.

- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  8  level request per requester; bit i requests the decoder.
- gnt_idx  output  3  decoder select (decoder `in`); index of current owner.
- gnt_en  output  1  decoder enable; 1 while a grant is active.
- gnt_onehot  output  8  registered one-hot grant, equal to decoder output: (1 << gnt_idx) when gnt_en=1, else 0.
- preempt  output  1  one-cycle pulse when a grant was taken by hold-limit expiry.

## Operation
- Reset values: gnt_idx=0, gnt_en=0, gnt_onehot=8'h00, preempt=0, state IDLE, hold_cnt=0, ptr=7. Index 0 therefore wins the first arbitration.
- All outputs are registered. No combinational path from req to outputs.
- Round-robin search: scan candidate indices ptr+1, ptr+2, … ptr+8, all mod 8. The first set req bit wins. On every new grant, ptr is loaded with the winner.
- State IDLE:
  - If req==0, stay in IDLE.
  - Otherwise grant the search winner: gnt_en=1, hold_cnt=0, go to GRANT.
- State GRANT (owner o = gnt_idx):
  - **Release:** req[o]=0. If any other bit is set, grant the search winner in the same edge (no idle bubble) with hold_cnt=0. Otherwise gnt_en=0, gnt_onehot=0, return to IDLE. gnt_idx keeps its last value.
  - **Expiry:** req[o]=1, hold_cnt==MAX_HOLD-1, and any other bit set. Grant the search winner excluding o, set hold_cnt=0, pulse preempt=1.
  - **Otherwise:** keep the owner. hold_cnt increments, saturating at MAX_HOLD-1.
- Expiry with no other requester: the owner keeps the grant indefinitely. hold_cnt stays saturated and expiry is re-evaluated every cycle.
- MAX_HOLD=1: under contention, ownership rotates every cycle.
- preempt is 0 on every cycle not following an expiry transition.
- gnt_onehot always equals the decoder function of (gnt_en, gnt_idx).

## Timing
- Latency from req rising to gnt_en: 1 clock. A request sampled at edge N is visible after edge N.
- Release latency: an owner dropping req before edge N loses the grant at edge N. The next owner is valid from edge N.
- Maximum wait for requester i under full contention: 7*MAX_HOLD cycles.
- Reset asserted mid-grant: all outputs clear immediately, without waiting for a clock. After rst_n deasserts, arbitration restarts with ptr=7. The first grant is 1 edge after the first sampled request.
- Simultaneous release by the owner and a new request: the new request is included in the same-edge search.

## Test plan
- **Reset:** hold rst_n=0 with req=8'hFF. Required: gnt_en=0, gnt_onehot=8'h00, preempt=0. Release reset: gnt_idx=0, gnt_onehot=8'h01 one edge later.
- **Single requester:** req=8'h20 from IDLE. Required: after 1 edge gnt_idx=5, gnt_onehot=8'h20. Drop req: gnt_en=0 on the next edge.
- **Contention and wrap-around:** MAX_HOLD=4, ptr=7, req=8'h81 held. Required sequence: idx 0 for 4 cycles, then idx 7 with preempt=1 for 1 cycle, 4 cycles, then idx 0 with preempt=1 again.
- **Handover:** req=8'h0C, owner 2. Drop bit 2 only. Required: idx 3 on the next edge, gnt_en stays 1 with no bubble, preempt=0.
- **Lone owner, no expiry:** req=8'h10 held for 20 cycles, MAX_HOLD=4. Required: idx 4 throughout, preempt never 1.
- **Reset mid-grant:** owner 6, assert rst_n=0 between edges. Required: gnt_en and gnt_onehot clear immediately. After release with req=8'h41: idx 0 is granted first.
